// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the fetch PC, reads instruction memory over req/ack and buffers up to two words for decode.
// Optional build macro IFU_ALIGN_CHECK_EN adds the fetch_misaligned flag and a HALT state for unaligned redirects.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        fi_valid,
  output logic [31:0] fi_instruction,
  output logic [31:0] fi_pc,
  input  logic        fd_ready,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc
`ifdef IFU_ALIGN_CHECK_EN
  ,
  output logic        fetch_misaligned
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
`ifdef IFU_ALIGN_CHECK_EN
    ,
    S_HALT  = 2'd3
`endif
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] redirect_tgt;
  logic        push;
  logic        pop;
  logic [1:0]  count;
  logic [1:0]  count_next;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [31:0] q_instr [2];
  logic [31:0] q_pc    [2];

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  // Only a REQ-state ack carries live data; drained or redirect-coincident acks are discarded.
  assign push = mem_req && mem_ack && (state == S_REQ) && !redirect_en;
  assign pop  = fi_valid && fd_ready;

  assign fi_valid       = (count != 2'd0);
  assign fi_instruction = fi_valid ? q_instr[rd_ptr] : 32'd0;
  assign fi_pc          = fi_valid ? q_pc[rd_ptr]    : 32'd0;

  always_comb begin
    count_next = count;
    if (redirect_en)
      count_next = 2'd0;
    else if (push && !pop)
      count_next = count + 2'd1;
    else if (pop && !push)
      count_next = count - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      count <= count_next;
      if (redirect_en) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= mem_rdata;
      q_pc[wr_ptr]    <= mem_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      mem_req  <= 1'b0;
      mem_addr <= RESET_VECTOR;
      fetch_pc <= RESET_VECTOR;
`ifdef IFU_ALIGN_CHECK_EN
      fetch_misaligned <= 1'b0;
`endif
    end else if (redirect_en) begin
      fetch_pc <= redirect_tgt;
`ifdef IFU_ALIGN_CHECK_EN
      fetch_misaligned <= (redirect_pc[1:0] != 2'b00);
`endif
      // A pending request cannot be withdrawn, so it is drained with its address held.
      if (mem_req && !mem_ack) begin
        state <= S_DRAIN;
      end
`ifdef IFU_ALIGN_CHECK_EN
      else if (redirect_pc[1:0] != 2'b00) begin
        state   <= S_HALT;
        mem_req <= 1'b0;
      end
`endif
      else begin
        state    <= S_REQ;
        mem_req  <= 1'b1;
        mem_addr <= redirect_tgt;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (count != 2'd2) begin
            state    <= S_REQ;
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            fetch_pc <= fetch_pc + 32'd4;
            if (count_next != 2'd2) begin
              mem_addr <= fetch_pc + 32'd4;
            end else begin
              state   <= S_IDLE;
              mem_req <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (mem_ack) begin
`ifdef IFU_ALIGN_CHECK_EN
            if (fetch_misaligned) begin
              state   <= S_HALT;
              mem_req <= 1'b0;
            end else begin
              state    <= S_REQ;
              mem_addr <= fetch_pc;
            end
`else
            state    <= S_REQ;
            mem_addr <= fetch_pc;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus a randomized run against a queue-level reference model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        fi_valid;
  logic [31:0] fi_instruction;
  logic [31:0] fi_pc;
  logic        fd_ready = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
`ifdef IFU_ALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  int total = 0;
  int bad = 0;

  instruction_fetch_unit #(.RESET_VECTOR(RV)) dut (
    .clk(clk),
    .reset(reset),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .fi_valid(fi_valid),
    .fi_instruction(fi_instruction),
    .fi_pc(fi_pc),
    .fd_ready(fd_ready),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc)
`ifdef IFU_ALIGN_CHECK_EN
    ,
    .fetch_misaligned(fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the prefetch queue must hold and which address the bus must show.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  logic [31:0] drain_addr;
  logic [31:0] hold_addr;
  bit          drain;
  bit          hold;
  bit          exp_req;
  bit          mis;
  int          strike;

  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      m_pc = RV;
      drain = 0;
      hold = 0;
      exp_req = 0;
      mis = 0;
      strike = 0;
    end else begin
      chk("fi_valid", {63'd0, fi_valid}, {63'd0, q.size() != 0});
      if (q.size() != 0) begin
        chk("fi_instruction", {32'd0, fi_instruction}, {32'd0, q[0].instr});
        chk("fi_pc", {32'd0, fi_pc}, {32'd0, q[0].pc});
      end
      if (mem_req)
        chk("mem_addr", {32'd0, mem_addr}, {32'd0, drain ? drain_addr : m_pc});
      if (hold) begin
        chk("req_hold", {63'd0, mem_req}, 64'd1);
        chk("addr_hold", {32'd0, mem_addr}, {32'd0, hold_addr});
      end
      if (exp_req)
        chk("req_resume", {63'd0, mem_req}, 64'd1);
      if (mis && !drain)
        chk("halt_no_req", {63'd0, mem_req}, 64'd0);
`ifdef IFU_ALIGN_CHECK_EN
      chk("misaligned", {63'd0, fetch_misaligned}, {63'd0, mis});
`endif
      chk("occupancy", {63'd0, (q.size() + ((mem_req && !drain) ? 1 : 0)) <= 2}, 64'd1);
      if (!mem_req && q.size() < 2 && !mis) strike++;
      else strike = 0;
      chk("idle_stall", {63'd0, strike < 2}, 64'd1);

      // Advance the model across the coming edge.
      hold = mem_req && !mem_ack;
      hold_addr = mem_addr;
      if (redirect_en) begin
        q.delete();
        if (drain) begin
          if (mem_req && mem_ack) drain = 0;
        end else if (mem_req && !mem_ack) begin
          drain = 1;
          drain_addr = m_pc;
        end
        m_pc = redirect_pc & 32'hFFFF_FFFC;
`ifdef IFU_ALIGN_CHECK_EN
        mis = (redirect_pc[1:0] != 2'b00);
`endif
        exp_req = !drain && !mis;
      end else if (drain) begin
        exp_req = 0;
        if (mem_req && mem_ack) begin
          drain = 0;
          exp_req = !mis;
        end
      end else begin
        exp_req = 0;
        if (fi_valid && fd_ready && q.size() != 0) void'(q.pop_front());
        if (mem_req && mem_ack) begin
          q.push_back('{instr: mem_rdata, pc: m_pc});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ack = 1'b0;
    fd_ready = 1'b0;
    redirect_en = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  int          acks;
  logic [31:0] rp;

  initial begin
    // Reset values
    repeat (3) tick();
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_mem_addr", {32'd0, mem_addr}, {32'd0, RV});
    chk("rst_fi_valid", {63'd0, fi_valid}, 64'd0);
    chk("rst_fi_instruction", {32'd0, fi_instruction}, 64'd0);
    chk("rst_fi_pc", {32'd0, fi_pc}, 64'd0);
`ifdef IFU_ALIGN_CHECK_EN
    chk("rst_misaligned", {63'd0, fetch_misaligned}, 64'd0);
`endif

    // Zero-wait streaming
    do_reset();
    fd_ready = 1'b1;
    tick();
    chk("first_req", {63'd0, mem_req}, 64'd1);
    chk("first_addr", {32'd0, mem_addr}, 64'h100);
    for (int k = 0; k < 6; k++) begin
      mem_ack = 1'b1;
      mem_rdata = $urandom;
      tick();
      chk("stream_addr", {32'd0, mem_addr}, 64'h104 + 64'(4 * k));
      chk("stream_valid", {63'd0, fi_valid}, 64'd1);
      chk("stream_pc", {32'd0, fi_pc}, 64'h100 + 64'(4 * k));
    end
    mem_ack = 1'b0;

    // Decode stalled: exactly two acks fill the queue
    do_reset();
    fd_ready = 1'b0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      mem_ack = mem_req;
      mem_rdata = $urandom;
      if (mem_ack) acks++;
      tick();
    end
    mem_ack = 1'b0;
    chk("stall_acks", 64'(acks), 64'd2);
    chk("stall_req_low", {63'd0, mem_req}, 64'd0);
    chk("stall_head", {32'd0, fi_pc}, 64'h100);
    fd_ready = 1'b1;
    tick();
    chk("drain_second", {32'd0, fi_pc}, 64'h104);
    chk("drain_second_v", {63'd0, fi_valid}, 64'd1);
    for (int k = 0; k < 4 && !mem_req; k++) tick();
    chk("resume_req", {63'd0, mem_req}, 64'd1);
    chk("resume_addr", {32'd0, mem_addr}, 64'h108);

    // Slow memory: request held until ack
    do_reset();
    fd_ready = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("slow_req", {63'd0, mem_req}, 64'd1);
      chk("slow_addr", {32'd0, mem_addr}, 64'h100);
      tick();
    end
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    chk("slow_valid", {63'd0, fi_valid}, 64'd1);
    chk("slow_instr", {32'd0, fi_instruction}, 64'hDEAD_BEEF);
    chk("slow_pc", {32'd0, fi_pc}, 64'h100);

    // Redirect while a request is outstanding
    do_reset();
    fd_ready = 1'b1;
    tick();
    for (int k = 0; k < 10 && mem_addr != 32'h10C; k++) begin
      mem_ack = 1'b1;
      mem_rdata = $urandom;
      tick();
    end
    chk("reach_10c", {32'd0, mem_addr}, 64'h10C);
    mem_ack = 1'b0;
    tick();
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_2000;
    tick();
    redirect_en = 1'b0;
    chk("redir_flush", {63'd0, fi_valid}, 64'd0);
    chk("drain_req", {63'd0, mem_req}, 64'd1);
    chk("drain_addr", {32'd0, mem_addr}, 64'h10C);
    tick();
    chk("drain_addr2", {32'd0, mem_addr}, 64'h10C);
    mem_ack = 1'b1;
    mem_rdata = 32'hBADB_AD00;
    tick();
    chk("post_drain_req", {63'd0, mem_req}, 64'd1);
    chk("post_drain_addr", {32'd0, mem_addr}, 64'h2000);
    chk("drained_dropped", {63'd0, fi_valid}, 64'd0);
    mem_rdata = 32'h1234_5678;
    tick();
    chk("target_valid", {63'd0, fi_valid}, 64'd1);
    chk("target_pc", {32'd0, fi_pc}, 64'h2000);
    chk("target_instr", {32'd0, fi_instruction}, 64'h1234_5678);

    // Redirect with coincident ack, then PC wrap
    redirect_en = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_en = 1'b0;
    chk("wrap_flush", {63'd0, fi_valid}, 64'd0);
    chk("wrap_req", {63'd0, mem_req}, 64'd1);
    chk("wrap_addr", {32'd0, mem_addr}, 64'hFFFF_FFFC);
    tick();
    chk("wrap_next", {32'd0, mem_addr}, 64'h0);
    chk("wrap_pc", {32'd0, fi_pc}, 64'hFFFF_FFFC);
    tick();
    chk("wrap_pc0", {32'd0, fi_pc}, 64'h0);
    mem_ack = 1'b0;

`ifdef IFU_ALIGN_CHECK_EN
    // Unaligned target halts fetch until an aligned redirect
    mem_ack = mem_req;
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_2002;
    tick();
    redirect_en = 1'b0;
    mem_ack = 1'b0;
    chk("mis_flag", {63'd0, fetch_misaligned}, 64'd1);
    for (int k = 0; k < 4; k++) begin
      chk("mis_no_req", {63'd0, mem_req}, 64'd0);
      tick();
    end
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_3000;
    tick();
    redirect_en = 1'b0;
    chk("mis_clear", {63'd0, fetch_misaligned}, 64'd0);
    chk("mis_resume_req", {63'd0, mem_req}, 64'd1);
    chk("mis_resume_addr", {32'd0, mem_addr}, 64'h3000);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(299) == 0);
      mem_ack = mem_req && ($urandom_range(99) < 70);
      mem_rdata = $urandom;
      fd_ready = ($urandom_range(99) < 60);
      redirect_en = ($urandom_range(99) < 4);
      rp = $urandom;
      if ($urandom_range(3) != 0) rp[1:0] = 2'b00;
      redirect_pc = rp;
      tick();
    end
    reset = 1'b0;
    redirect_en = 1'b0;
    mem_ack = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Upstream fetch stage of the CPU pipeline: owns the fetch program counter, issues word reads to instruction memory over a req/ack handshake, and buffers up to two fetched words in a prefetch queue. The logic control / decode stage consumes the queue through a valid/ready handshake. A taken branch or PC write from execute redirects the fetch PC and flushes all queued and in-flight instructions.

## Interface
Parameters:
- `RESET_VECTOR`, 32'h0000_0000, first fetch address after reset (word aligned).

Ports:
- `clk`  in  1  the single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_req`  out  1  read request to instruction memory.
- `mem_addr`  out  32  word address of the request; bits [1:0] always 0.
- `mem_ack`  in  1  request accepted; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32  instruction word.
- `fi_valid`  out  1  head of queue holds a valid instruction.
- `fi_instruction`  out  32  head instruction.
- `fi_pc`  out  32  address of the head instruction.
- `fd_ready`  in  1  decode accepts the head this cycle.
- `redirect_en`  in  1  taken branch or PC write; flush and refetch.
- `redirect_pc`  in  32  new fetch address.
- `fetch_misaligned`  out  1  present only with `IFU_ALIGN_CHECK_EN`.

## Operation
- State machine states: IDLE, REQ, DRAIN, HALT. HALT exists only with the macro.
- IDLE:
  - `mem_req`=0.
  - Move to REQ when occupancy + outstanding < 2.
- REQ:
  - `mem_req`=1. `mem_addr`=fetch_pc, held stable until `mem_ack`.
  - On ack: write `{mem_rdata, fetch_pc}` to the queue tail and set fetch_pc += 4, wrapping modulo 2^32.
  - After the ack, stay in REQ if space remains. Otherwise go to IDLE.
- Queue:
  - 2-entry FIFO with 1-bit read/write pointers and a 2-bit count.
  - Pop when `fi_valid && fd_ready`.
  - Push and pop in the same cycle leave the count unchanged.
  - A request is issued only when count + outstanding < 2, so an ack never meets a full queue.
- Redirect (highest priority):
  - Queue count is cleared and fetch_pc is loaded with `{redirect_pc[31:2],2'b00}`.
  - If no request is outstanding, go to REQ.
  - If a request is outstanding and not acked in this cycle, go to DRAIN.
  - A pop in the same cycle has no further effect.
  - An ack in the same cycle is discarded.
- DRAIN:
  - `mem_req` and the old `mem_addr` stay asserted (the bus rule forbids withdrawing a request).
  - On ack, the data is dropped and the state goes to REQ at the new fetch_pc.
  - A second redirect while in DRAIN only replaces fetch_pc.

## Timing
- Reset values:
  - `mem_req`=0, `mem_addr`=`RESET_VECTOR`.
  - `fi_valid`=0, `fi_instruction`=0, `fi_pc`=0.
  - `fetch_misaligned`=0.
  - State IDLE, count 0, both pointers 0.
- Reset asserted mid-transaction drops the outstanding request and any queued data. Memory must tolerate a withdrawn request on reset.
- `mem_req` rises in the first cycle after `reset` deasserts.
- Ack at edge N gives `fi_valid`=1 after edge N. Minimum fetch-to-decode latency is 1 cycle after ack.
- Zero-wait memory (ack every cycle) sustains 1 instruction/cycle while `fd_ready`=1.
- Redirect at edge N:
  - `fi_valid`=0 after edge N.
  - `mem_addr`=new target after edge N, or after the drain ack if a request was outstanding.
  - Redirect-to-first-valid is 2 cycles minimum with zero-wait memory.
- `fi_instruction` and `fi_pc` are stable while `fi_valid`=1 and `fd_ready`=0.

## Configuration
- Macro `IFU_ALIGN_CHECK_EN`.
- Defined:
  - A redirect with `redirect_pc[1:0]`≠0 sets `fetch_misaligned`=1 and enters HALT. If a request is outstanding, the drain completes first.
  - In HALT no requests are issued and the queue stays empty.
  - The next aligned redirect clears the flag and resumes fetching.
- Undefined:
  - Port and HALT are absent.
  - The low two bits of the target are silently forced to 0.

## Test plan
- Reset release, `RESET_VECTOR`=0x100, zero-wait memory, `fd_ready`=1 -> requests 0x100, 0x104, 0x108 on consecutive cycles; `fi_pc` follows the same sequence one cycle behind.
- `fd_ready`=0 held -> exactly two acks accepted and `mem_req` drops. Raise `fd_ready` -> entries appear in order 0x100 then 0x104, and fetch resumes at 0x108.
- Ack delayed 3 cycles -> `mem_addr` stays stable and `mem_req` stays high throughout; the queue receives the correct word.
- Redirect to 0x2000 while a request to 0x10C is unacked -> DRAIN holds 0x10C until ack, the returned word never reaches `fi_valid`, and the next request is 0x2000.
- fetch_pc = 0xFFFF_FFFC -> next fetch address wraps to 0x0000_0000.
- With `IFU_ALIGN_CHECK_EN`: redirect to 0x2002 -> `fetch_misaligned`=1 and no further `mem_req`. Redirect to 0x3000 -> flag clears and 0x3000 is requested.
